// File: rtl/word_arith_seq_if.sv
// Valid/ready operand and result channel for word_arith_seq.
// The slave modport is the sequencer's view; master is the producer/consumer side.
interface word_arith_seq_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic         out_dz;
  logic         busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_dz, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_dz, busy
  );
endinterface

// File: rtl/word_arith_seq.sv
// Sequenced word datapath: out = (((x+K_ADD)^2 * (x-K_SUB)) / K_DIV) % (x+K_ADD), mod 2^W.
// One FSM shares a power step and a restoring divider across the whole chain.
module word_arith_seq #(
  parameter int W     = 8,
  parameter int K_ADD = 1,
  parameter int K_SUB = 2,
  parameter int K_DIV = 3
) (
  input  logic              clk,
  input  logic              rst,
  word_arith_seq_if.slave   bus
);
  localparam int           CW      = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0] K_ADD_W = W'(K_ADD);
  localparam logic [W-1:0] K_SUB_W = W'(K_SUB);
  localparam logic [W-1:0] K_DIV_W = W'(K_DIV);
  localparam logic [W-1:0] EXP     = W'(2);
  localparam logic [CW-1:0] LAST   = CW'(W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SUB, S_POW, S_MUL, S_DIV, S_MOD, S_DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  x_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  c_reg;
  logic [W-1:0]  acc;
  logic [W-1:0]  div_rem;
  logic [W-1:0]  div_q;
  logic [CW-1:0] cnt;
  logic          dz;
  logic          out_valid_r;
  logic [W-1:0]  out_data_r;
  logic          out_dz_r;

  logic [CW-1:0] exp_idx;
  logic [W-1:0]  acc_sq;
  logic [W-1:0]  pow_next;
  logic [W-1:0]  divisor;
  logic [W:0]    div_sh;
  logic          div_ge;
  logic [W-1:0]  rem_next;
  logic [W-1:0]  q_next;

  // One square-and-multiply step and one restoring-division step; div_q
  // shifts the dividend out of its MSB while quotient bits enter at the LSB.
  always_comb begin
    exp_idx  = LAST - cnt;
    acc_sq   = acc * acc;
    pow_next = EXP[exp_idx] ? W'(acc_sq * a_reg) : acc_sq;
    divisor  = (state == S_MOD) ? a_reg : K_DIV_W;
    div_sh   = {div_rem, div_q[W-1]};
    div_ge   = (div_sh >= {1'b0, divisor});
    rem_next = div_ge ? (div_sh[W-1:0] - divisor) : div_sh[W-1:0];
    q_next   = {div_q[W-2:0], div_ge};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      x_reg       <= '0;
      a_reg       <= '0;
      c_reg       <= '0;
      acc         <= '0;
      div_rem     <= '0;
      div_q       <= '0;
      cnt         <= '0;
      dz          <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_dz_r    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            x_reg <= bus.in_data;
            dz    <= 1'b0;
            state <= S_ADD;
          end
        end
        S_ADD: begin
          a_reg <= x_reg + K_ADD_W;
          state <= S_SUB;
        end
        S_SUB: begin
          c_reg <= x_reg - K_SUB_W;
          acc   <= W'(1);
          cnt   <= '0;
          state <= S_POW;
        end
        S_POW: begin
          acc <= pow_next;
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= S_MUL;
          end
        end
        S_MUL: begin
          div_q   <= acc * c_reg;
          div_rem <= '0;
          cnt     <= '0;
          state   <= S_DIV;
        end
        // The DIV quotient becomes the MOD dividend in place.
        S_DIV: begin
          div_q   <= q_next;
          div_rem <= rem_next;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            div_rem <= '0;
            cnt     <= '0;
            dz      <= dz | (K_DIV_W == '0);
            state   <= S_MOD;
          end
        end
        S_MOD: begin
          div_q   <= q_next;
          div_rem <= rem_next;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt         <= '0;
            out_data_r  <= rem_next;
            out_dz_r    <= dz | (a_reg == '0);
            out_valid_r <= 1'b1;
            state       <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            state       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_dz    = out_dz_r;
endmodule

// File: tb/tb_word_arith_seq.sv
// Randomized bench for word_arith_seq against a plain-arithmetic reference model.
module tb_word_arith_seq;
  localparam int W     = 8;
  localparam int K_ADD = 1;
  localparam int K_SUB = 2;
  localparam int K_DIV = 3;
  localparam int LAT   = 3 + 3 * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  word_arith_seq_if #(.W(W)) bus ();

  word_arith_seq #(.W(W), .K_ADD(K_ADD), .K_SUB(K_SUB), .K_DIV(K_DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference: the formula evaluated directly with W-bit wraparound.
  function automatic logic [W-1:0] model(input logic [W-1:0] x, output logic dz);
    logic [W-1:0] a, b, c, d, e;
    a  = x + W'(K_ADD);
    c  = x - W'(K_SUB);
    b  = a * a;
    d  = b * c;
    dz = 1'b0;
    if (K_DIV == 0) begin
      e  = '1;
      dz = 1'b1;
    end else begin
      e = d / W'(K_DIV);
    end
    if (a == '0) begin
      dz = 1'b1;
      return e;
    end
    return e % a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] x);
    bus.in_valid = 1'b1;
    bus.in_data  = x;
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = $urandom_range(0, 255);
  endtask

  task automatic wait_done(output int cyc, output bit ok, output int ready_seen);
    cyc = 0;
    ok = 1'b0;
    ready_seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.out_valid) begin
        ok = 1'b1;
        break;
      end
      if (bus.in_ready) ready_seen++;
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got v=%b r=%b b=%b expected v=0 r=1 b=0",
               bus.out_valid, bus.in_ready, bus.busy);
    end
    vectors++;
    if (bus.out_data !== '0 || bus.out_dz !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got data=%0d dz=%b expected 0/0", bus.out_data, bus.out_dz);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int cyc, rs;
    bit ok;
    bus.out_ready = 1'b1;
    send(8'd4);
    vectors++;
    if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_accept: got in_ready=%b busy=%b expected 0/1", bus.in_ready, bus.busy);
    end
    wait_done(cyc, ok, rs);
    vectors++;
    if (!ok || cyc !== LAT) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: got %0d cycles (ok=%b) expected %0d", cyc, ok, LAT);
    end
    vectors++;
    if (bus.out_data !== 8'd1 || bus.out_dz !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL basic_data: got %0d dz=%b expected 1 dz=0", bus.out_data, bus.out_dz);
    end
    tick();
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_handshake: got v=%b r=%b expected v=0 r=1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] xs [4];
    logic [W-1:0] exp_v;
    logic exp_dz;
    int cyc, rs;
    bit ok;
    xs = '{8'd0, 8'd1, 8'd3, 8'd5};
    bus.out_ready = 1'b1;
    foreach (xs[k]) begin
      vectors++;
      if (bus.in_ready !== 1'b1) begin
        miscompares++;
        $display("[TB] FAIL b2b_ready_%0d: got in_ready=%b expected 1", k, bus.in_ready);
      end
      send(xs[k]);
      wait_done(cyc, ok, rs);
      exp_v = model(xs[k], exp_dz);
      vectors++;
      if (!ok || cyc !== LAT || rs !== 0) begin
        miscompares++;
        $display("[TB] FAIL b2b_timing_%0d: got %0d cycles ready_seen=%0d expected %0d and 0",
                 k, cyc, rs, LAT);
      end
      vectors++;
      if (bus.out_data !== exp_v || bus.out_dz !== exp_dz) begin
        miscompares++;
        $display("[TB] FAIL b2b_data_x%0d: got %0d dz=%b expected %0d dz=%b",
                 xs[k], bus.out_data, bus.out_dz, exp_v, exp_dz);
      end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int cyc, rs;
    bit ok;
    bus.out_ready = 1'b1;
    send(8'd255);
    wait_done(cyc, ok, rs);
    vectors++;
    if (!ok || bus.out_data !== 8'd0 || bus.out_dz !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL divzero: got %0d dz=%b ok=%b expected 0 dz=1", bus.out_data, bus.out_dz, ok);
    end
    tick();
  endtask

  task automatic test_stall();
    int cyc, rs, bad;
    bit ok;
    bus.out_ready = 1'b0;
    send(8'd10);
    wait_done(cyc, ok, rs);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("[TB] FAIL stall_timeout: got no out_valid expected out_valid=1");
    end
    bad = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'd77;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd0 || bus.out_dz !== 1'b0 ||
          bus.in_ready !== 1'b0)
        bad++;
      tick();
    end
    bus.in_valid = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL stall_hold: got %0d unstable cycles expected 0", bad);
    end
    bus.out_ready = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
      tick();
    end
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("[TB] FAIL stall_single_handshake: got %0d busy/valid cycles expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, rs;
    bit ok;
    bus.out_ready = 1'b1;
    send(8'd4);
    for (int i = 0; i < 6; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL midreset: got busy=%b r=%b v=%b expected 0/1/0",
               bus.busy, bus.in_ready, bus.out_valid);
    end
    send(8'd3);
    wait_done(cyc, ok, rs);
    vectors++;
    if (!ok || cyc !== LAT || bus.out_data !== 8'd1) begin
      miscompares++;
      $display("[TB] FAIL midreset_next: got %0d after %0d cycles expected 1 after %0d",
               bus.out_data, cyc, LAT);
    end
    tick();
  endtask

  task automatic test_random();
    logic [W-1:0] x, exp_v;
    logic exp_dz;
    int cyc, rs;
    bit ok;
    bus.out_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      x = (n == 0) ? 8'd1 : (n == 1) ? 8'd255 : W'($urandom_range(0, 255));
      exp_v = model(x, exp_dz);
      send(x);
      wait_done(cyc, ok, rs);
      vectors++;
      if (!ok || bus.out_data !== exp_v || bus.out_dz !== exp_dz) begin
        miscompares++;
        $display("[TB] FAIL random_x%0d: got %0d dz=%b ok=%b expected %0d dz=%b",
                 x, bus.out_data, bus.out_dz, ok, exp_v, exp_dz);
      end
      tick();
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_stall();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
